// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline front end.
package mips_pkg;

  // Fetch controller states.
  //   REQ   : request pulse issued at PcF this cycle
  //   WAIT  : request outstanding, waiting for the response
  //   HOLD  : response parked in the buffer while decode is stalled
  //   DRAIN : wrong-path response still outstanding, will be dropped
  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;  // sll $0,$0,0
  localparam logic [31:0] PC_INC    = 32'd4;
  localparam int          IF_ID_W   = 64;             // {instr, pc_plus4}

  // Jump-target field slices: upper PC bits come from PC+4, the word
  // index comes from the instruction.
  localparam int JT_PC_MSB  = 31;
  localparam int JT_PC_LSB  = 28;
  localparam int JT_IDX_MSB = 25;
  localparam int JT_IDX_LSB = 0;

  // J-type target: {PC+4[31:28], instr_index, 2'b00}.
  function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                              input logic [31:0] instr);
    return {pc_plus4[JT_PC_MSB:JT_PC_LSB], instr[JT_IDX_MSB:JT_IDX_LSB], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_register.sv
// Pipeline register with load enable and synchronous clear-to-bubble.
// Also intended for reuse as the ID/EX register.
module if_id_register
  import mips_pkg::*;
#(
  parameter int              W       = IF_ID_W,
  parameter logic [W-1:0]    CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Reset and clear both load the bubble value; clear only acts when enabled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= CLR_VAL;
    end else if (i_en) begin
      r_q <= i_clr ? CLR_VAL : i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage plus IF/ID register.
//
// Instruction memory handshake: ImemReq is a one-cycle pulse carrying
// ImemAddr; memory answers with exactly one ImemValid strobe (with ImemRdata)
// one or more cycles later, in order, and never has more than one access
// outstanding. There is no ready signal: the fetch side never issues a new
// request until the previous response has been seen, so the memory can
// always accept. A response that arrives after a redirect is consumed
// (DRAIN) but never forwarded to decode.
module fetch_stage
  import mips_pkg::fetch_state_t, mips_pkg::REQ, mips_pkg::WAIT,
         mips_pkg::HOLD, mips_pkg::DRAIN, mips_pkg::PC_INC,
         mips_pkg::IF_ID_W, mips_pkg::jump_target;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic         CLk,
  input  logic         Reset,
  input  logic         StallD,
  input  logic [1:0]   PcScrD,
  input  logic [31:0]  PcBranchD,
  output logic         ImemReq,
  output logic [31:0]  ImemAddr,
  input  logic [31:0]  ImemRdata,
  input  logic         ImemValid,
  output logic [31:0]  InstrD,
  output logic [31:0]  PcPlus4D,
  output logic         FetchBusyF,
  output fetch_state_t o_state
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  logic [31:0]  r_pc;
  logic [31:0]  r_buf_instr;
  logic [31:0]  w_pc_nxt;
  logic [31:0]  w_target;
  logic [31:0]  w_fetched;
  logic         w_redirect;
  logic         w_avail;
  logic         w_if_id_en;
  logic         w_if_id_clr;
  logic [IF_ID_W-1:0] w_if_id_d;
  logic [IF_ID_W-1:0] w_if_id_q;

  // A redirect is only honoured when decode is not stalled; a stalled
  // branch/jump will be re-presented once the stall clears.
  assign w_redirect = (PcScrD != 2'b00) && !StallD;
  assign w_target   = PcScrD[1] ? jump_target(PcPlus4D, InstrD) : PcBranchD;
  assign w_avail    = ((r_state == WAIT) && ImemValid) || (r_state == HOLD);
  assign w_fetched  = (r_state == HOLD) ? r_buf_instr : ImemRdata;

  // Next-state and next-PC selection, redirect first.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    if (w_redirect) begin
      w_pc_nxt = w_target;
      case (r_state)
        REQ:     w_state_nxt = DRAIN;
        WAIT:    w_state_nxt = ImemValid ? REQ : DRAIN;
        HOLD:    w_state_nxt = REQ;
        DRAIN:   w_state_nxt = ImemValid ? REQ : DRAIN;
        default: w_state_nxt = REQ;
      endcase
    end else if (w_avail) begin
      if (!StallD) begin
        w_pc_nxt    = r_pc + PC_INC;
        w_state_nxt = REQ;
      end else begin
        w_state_nxt = HOLD;
      end
    end else begin
      case (r_state)
        REQ:     w_state_nxt = WAIT;
        DRAIN:   w_state_nxt = ImemValid ? REQ : DRAIN;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // State, PC and stall buffer registers.
  always_ff @(posedge CLk) begin
    if (!Reset) begin
      r_state     <= REQ;
      r_pc        <= RESET_PC;
      r_buf_instr <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if ((r_state == WAIT) && ImemValid && StallD) begin
        r_buf_instr <= ImemRdata;
      end
    end
  end

  // IF/ID loads whenever decode is free; it gets a bubble unless a real
  // instruction is available and no redirect is flushing it.
  assign w_if_id_en  = !StallD || w_redirect;
  assign w_if_id_clr = w_redirect || !w_avail;
  assign w_if_id_d   = {w_fetched, r_pc + PC_INC};

  if_id_register #(
    .W       (IF_ID_W),
    .CLR_VAL ({NOP_INSTR, 32'h0000_0000})
  ) u_if_id (
    .clk   (CLk),
    .rst_n (Reset),
    .i_en  (w_if_id_en),
    .i_clr (w_if_id_clr),
    .i_d   (w_if_id_d),
    .o_q   (w_if_id_q)
  );

  assign InstrD     = w_if_id_q[63:32];
  assign PcPlus4D   = w_if_id_q[31:0];
  assign ImemReq    = (r_state == REQ) && Reset;
  assign ImemAddr   = r_pc;
  assign FetchBusyF = !w_avail;
  assign o_state    = r_state;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register. It is the producer side of the decode interface: it supplies InstrD/PcPlus4D to decode and consumes decode's redirect outputs PcScrD/PcBranchD. It owns PcF and a single-outstanding request/response port to instruction memory with variable latency of at least 1 cycle. It inserts NOP bubbles on memory wait and on redirect.

Parameters:
RESET_PC, 32'h0000_0000, PcF value after reset.
NOP_INSTR, 32'h0000_0000, bubble instruction (sll $0,$0,0) loaded into InstrD.

Ports:
CLk  input  1  clock; all state updates on rising edge.
Reset  input  1  synchronous reset, active-low.
StallD  input  1  hazard unit: hold IF/ID and PcF.
PcScrD  input  2  from decode: {jump, branch-taken}; 00 = sequential.
PcBranchD  input  32  branch target from decode.
ImemReq  output  1  single-cycle request pulse.
ImemAddr  output  32  request address (= PcF).
ImemRdata  input  32  instruction returned.
ImemValid  input  1  response strobe; responses are in order; at most one outstanding.
InstrD  output  32  IF/ID instruction.
PcPlus4D  output  32  IF/ID PC+4.
FetchBusyF  output  1  high when no instruction is ready for decode (state != HOLD and no live response this cycle).

Behaviour:
- Reset (Reset==0 at edge): PcF=RESET_PC, InstrD=NOP_INSTR, PcPlus4D=0, BufInstr=0, state=REQ. ImemReq is forced 0 while Reset==0.
- States:
  - REQ: ImemReq=1, ImemAddr=PcF.
  - WAIT: awaiting response.
  - HOLD: response buffered in BufInstr while decode is stalled.
  - DRAIN: awaiting a response that must be discarded.
- Redirect R = (PcScrD!=00) && !StallD.
- Redirect target: PcScrD[1] ? {PcPlus4D[31:28], InstrD[25:0], 2'b00} : PcBranchD. PcScrD=11 is treated as jump.
- Fetched-available F = (state==WAIT && ImemValid) || state==HOLD.
- Per-edge priority:
  1. R: PcF<=target; InstrD<=NOP_INSTR; PcPlus4D<=0. Next state:
     - REQ if the outstanding access completes this cycle (state WAIT with ImemValid) or there is none (HOLD).
     - DRAIN if still pending (state REQ, or WAIT without ImemValid).
     - DRAIN stays DRAIN until ImemValid.
     Any F this cycle is wrong-path and dropped.
  2. F && !StallD: InstrD<=(HOLD ? BufInstr : ImemRdata); PcPlus4D<=PcF+4; PcF<=PcF+4; state<=REQ.
  3. F && StallD: in WAIT, BufInstr<=ImemRdata and state<=HOLD; in HOLD, hold. IF/ID and PcF hold.
  4. !F && !StallD: InstrD<=NOP_INSTR, PcPlus4D<=0 (bubble). State transitions:
     - REQ->WAIT.
     - DRAIN->REQ on ImemValid, else stay DRAIN.
     - WAIT stays WAIT.
  5. !F && StallD: IF/ID holds. REQ->WAIT and DRAIN->REQ-on-valid still advance.
- REQ always advances to WAIT (or DRAIN under R); the pulse lasts exactly one cycle.
- ImemValid in REQ or HOLD is a protocol violation and is ignored; assertion in bench.
- Arithmetic: PcF+4 is mod 2^32 and wraps 32'hFFFF_FFFC -> 0. PcF[1:0] stays 00 unless PcBranchD is misaligned; it is passed through unchecked.
- Throughput: one instruction per (L+1) cycles for memory latency L.
- Reset mid-operation overrides everything and discards any in-flight response. Instruction memory shares Reset.

Decomposition:
- Package mips_pkg: fetch_state_t enum {REQ, WAIT, HOLD, DRAIN}; NOP_INSTR; PC_INC=32'd4; jump-target field slices.
- Sub-module if_id_register: a 64-bit register with enable (!StallD or R) and synchronous clear-to-bubble. It is reused later for ID/EX.

Test Plan:
- Reset: hold Reset=0 for 3 cycles -> ImemReq=0, InstrD=0, PcPlus4D=0. In the first cycle after release, ImemReq=1 with ImemAddr=0.
- Sequential, L=1: mem[0]=0x20080005, mem[4]=0x20090007 -> InstrD=0x20080005/PcPlus4D=4 two edges after release, next ImemAddr=4, then InstrD=0x20090007/PcPlus4D=8. Bubbles (InstrD=0) appear between them.
- Stall hold: StallD=1 when the mem[4] response arrives -> state HOLD, InstrD unchanged, no ImemReq. Drop StallD -> InstrD=0x20090007 on the next edge, then ImemAddr=8.
- Branch during pending fetch: L=3, PcScrD=01, PcBranchD=0x40 while in WAIT -> InstrD=0, DRAIN. Late data 0xDEADBEEF never reaches InstrD; the next ImemAddr=0x40.
- Jump: InstrD=0x08000010, PcPlus4D=0x0000_0008, PcScrD=10 -> next ImemAddr=0x0000_0040, InstrD=0.
- Redirect and response in the same cycle, with StallD=1 suppressing R: PcScrD=01 with StallD=1 -> no redirect, instruction buffered. Then StallD=0 with PcScrD still 01 -> redirect taken, buffered instruction discarded, state REQ at PcBranchD.
